bcd7seg_mux: RTL and testbench
==============================

// Module: bcd7seg_mux
// PURPOSE
//   Time-multiplexed N-digit BCD to 7-segment display driver; successor to the
//   single-digit combinational decoder. Double-buffers a packed BCD word and
//   scans one digit per refresh period on shared a..g/dp lines with one-hot
//   digit enables. Adds leading-zero blanking and a registered out-of-range flag.
//   Sits between the datapath (counters, ALU result) and the board display pins.
// PARAMETERS
//   N_DIGITS     4      number of digits; 1..8
//   REFRESH_DIV  50000  clk cycles each digit stays lit; >=2
// PORTS
//   clk       in   1            rising-edge clock; single clock domain
//   rst_n     in   1            synchronous reset, active-low
//   en        in   1            1 = scan active; 0 = display dark, counters hold
//   load      in   1            1 = capture bcd_in/dp_in into shadow this edge
//   bcd_in    in   4*N_DIGITS   packed BCD; digit i = bcd_in[4i+3:4i], digit 0 = LSD
//   dp_in     in   N_DIGITS     decimal point per digit
//   lz_blank  in   1            1 = blank leading zeros
//   seg       out  7            {a,b,c,d,e,f,g}, active-high (seg[6]=a)
//   dp        out  1            decimal point of lit digit, active-high
//   an        out  N_DIGITS     one-hot digit enable, active-high
//   outrange  out  1            1 = some shadow digit > 9
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): shadow=0, dp_sh=0, cnt=0, idx=0, seg=0, dp=0,
//     an=0, outrange=0. Reset wins over load and en in the same cycle; a scan
//     in progress is abandoned and restarts at digit 0.
//   Load: load=1 at edge E -> shadow/dp_sh take bcd_in/dp_in at E. load is
//     honoured regardless of en. The display never mixes old and new digits
//     within one lit period except on the digit being lit at E.
//   Refresh: cnt counts 0..REFRESH_DIV-1 while en=1. On cnt==REFRESH_DIV-1 it
//     wraps to 0 and idx advances by 1; idx==N_DIGITS-1 wraps to 0.
//   Outputs are registered. At each edge with en=1: an <= one-hot(idx),
//     seg <= decode(shadow[idx]), dp <= dp_sh[idx]. Latency from idx change to
//     pins is 1 cycle. Each digit is lit for exactly REFRESH_DIV cycles.
//   en=0: at the next edge an=0, seg=0, dp=0; cnt and idx hold. en back to 1:
//     the scan resumes on the same digit with the remaining count.
//   Decode (abcdefg): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011
//     5=1011011 6=1011111 7=1110000 8=1111111 9=1111011; 10..15 -> 0000000.
//   Leading-zero blanking: with lz_blank=1, digit i is blank (seg=0) when
//     shadow digit i and every digit above it are 0. Digit 0 is never blanked.
//     dp is still driven on blanked digits. An out-of-range digit counts as
//     nonzero. an stays asserted on blanked digits.
//   outrange <= OR over i of (shadow[i] > 9), registered: a load at edge E
//     updates outrange at E+1. Not sticky; cleared by the next valid load.
//   Widths: cnt is clog2(REFRESH_DIV) bits; idx is clog2(N_DIGITS) bits, min 1.
// TESTING  (N_DIGITS=4, REFRESH_DIV=4)
//   Reset: rst_n=0 for 2 cycles with en=1 -> an=0000, seg=0, dp=0, outrange=0.
//   Scan: load 0x1234, en=1 -> an sequence 0001,0010,0100,1000, 4 cycles each;
//     seg 0110011,1111001,1101101,0110000; wraps back to 0001.
//   Blank: load 0x0050, lz_blank=1 -> digits 3,2 seg=0; digit1=1011011,
//     digit0=1111110. Load 0x0000 -> only digit 0 shows 1111110.
//   Outrange: load 0x9A01 -> outrange=1 one cycle after load; digit 2
//     seg=0000000; digit 3=1111011; load 0x9901 -> outrange=0 next cycle.
//   en/DP: dp_in=0010, en dropped mid-digit-1 for 10 cycles -> an=0000;
//     on resume digit 1 finishes its remaining cycles with dp=1.
//   Reset mid-scan on digit 2 -> next enabled edge an=0001, outrange=0.

Source files
------------

// File: rtl/bcd7seg_mux.sv
// Time-multiplexed N-digit BCD to 7-segment driver.
// Double-buffered digits, leading-zero blanking, registered range flag.
module bcd7seg_mux #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    outrange
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

    logic [3:0]          shadow [N_DIGITS];
    logic [N_DIGITS-1:0] dp_sh;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [N_DIGITS-1:0] blank;
    logic                above;
    logic                range_bad;
    logic [6:0]          seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // A digit is blankable when it and every digit above it are zero.
    always_comb begin
        blank = '0;
        above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            above    = above && (shadow[i] == 4'd0);
            blank[i] = above;
        end
    end

    always_comb begin
        range_bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            range_bad = range_bad | (shadow[i] > 4'd9);
        end
    end

    always_comb begin
        seg_nxt = decode(shadow[idx]);
        if (lz_blank && blank[idx]) begin
            seg_nxt = 7'b0000000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow[i] <= 4'd0;
            end
            dp_sh    <= '0;
            outrange <= 1'b0;
        end else begin
            if (load) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    shadow[i] <= bcd_in[4*i +: 4];
                end
                dp_sh <= dp_in;
            end
            outrange <= range_bad;
        end
    end

    // Counters hold while disabled so the scan resumes mid-digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (en) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= '0;
            seg <= '0;
            dp  <= 1'b0;
        end else if (en) begin
            an  <= N_DIGITS'(1) << idx;
            seg <= seg_nxt;
            dp  <= dp_sh[idx];
        end else begin
            an  <= '0;
            seg <= '0;
            dp  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd7seg_mux.sv
// Directed table-driven bench for bcd7seg_mux with 4 digits and
// a refresh period of 4 cycles, plus hand-written corner sequences.
module tb_bcd7seg_mux;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        outrange;

    int total = 0;
    int bad   = 0;

    bcd7seg_mux #(
        .N_DIGITS   (ND),
        .REFRESH_DIV(RD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .bcd_in  (bcd_in),
        .dp_in   (dp_in),
        .lz_blank(lz_blank),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .outrange(outrange)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     bcd;
        logic [3:0]      dpv;
        logic            lz;
        logic [3:0][6:0] sg;
        logic            orng;
    } vec_t;

    vec_t tv[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dark(input string name);
        check({name, "_an"}, 32'(an), 32'd0);
        check({name, "_seg"}, 32'(seg), 32'd0);
        check({name, "_dp"}, 32'(dp), 32'd0);
    endtask

    initial begin
        // sg lists digit 3 first, digit 0 last
        tv[0] = '{16'h1234, 4'b0000, 1'b0,
                  {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 1'b0};
        tv[1] = '{16'h0050, 4'b0000, 1'b1,
                  {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}, 1'b0};
        tv[2] = '{16'h0000, 4'b0000, 1'b1,
                  {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 1'b0};
        tv[3] = '{16'h9A01, 4'b0101, 1'b1,
                  {7'b1111011, 7'b0000000, 7'b1111110, 7'b0110000}, 1'b1};
        tv[4] = '{16'h9901, 4'b0000, 1'b0,
                  {7'b1111011, 7'b1111011, 7'b1111110, 7'b0110000}, 1'b0};
        tv[5] = '{16'h0050, 4'b1010, 1'b0,
                  {7'b1111110, 7'b1111110, 7'b1011011, 7'b1111110}, 1'b0};
        tv[6] = '{16'h0008, 4'b1000, 1'b1,
                  {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111}, 1'b0};
        tv[7] = '{16'h0F00, 4'b0000, 1'b1,
                  {7'b0000000, 7'b0000000, 7'b1111110, 7'b1111110}, 1'b1};
        tv[8] = '{16'h6789, 4'b0000, 1'b0,
                  {7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011}, 1'b0};

        rst_n    = 1'b0;
        en       = 1'b1;
        load     = 1'b0;
        bcd_in   = 16'h0;
        dp_in    = 4'h0;
        lz_blank = 1'b0;

        // Reset state
        step();
        step();
        check_dark("reset");
        check("reset_orng", 32'(outrange), 32'd0);

        // Table: reset, load with scan stopped, then one full scan + wrap
        for (int v = 0; v < 9; v++) begin
            rst_n    = 1'b0;
            en       = 1'b0;
            load     = 1'b0;
            step();
            rst_n    = 1'b1;
            load     = 1'b1;
            bcd_in   = tv[v].bcd;
            dp_in    = tv[v].dpv;
            lz_blank = tv[v].lz;
            step();
            load   = 1'b0;
            bcd_in = 16'hFFFF;
            dp_in  = 4'hF;
            check_dark($sformatf("v%0d_idle", v));
            en = 1'b1;
            for (int k = 0; k <= ND * RD; k++) begin
                int d;
                step();
                d = (k / RD) % ND;
                check($sformatf("v%0d_k%0d_an", v, k), 32'(an),
                      32'(4'b0001 << d));
                check($sformatf("v%0d_k%0d_seg", v, k), 32'(seg),
                      32'(tv[v].sg[d]));
                check($sformatf("v%0d_k%0d_dp", v, k), 32'(dp),
                      32'(tv[v].dpv[d]));
                check($sformatf("v%0d_k%0d_orng", v, k), 32'(outrange),
                      32'(tv[v].orng));
            end
        end

        // Outrange latency and clearing
        rst_n = 1'b0;
        en    = 1'b0;
        step();
        rst_n  = 1'b1;
        load   = 1'b1;
        bcd_in = 16'h9A01;
        step();
        load = 1'b0;
        check("orng_lag0", 32'(outrange), 32'd0);
        step();
        check("orng_set", 32'(outrange), 32'd1);
        load   = 1'b1;
        bcd_in = 16'h9901;
        step();
        load = 1'b0;
        check("orng_hold", 32'(outrange), 32'd1);
        step();
        check("orng_clr", 32'(outrange), 32'd0);

        // en drop mid-digit-1: dark, then digit 1 finishes remaining count
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        load     = 1'b1;
        bcd_in   = 16'h1234;
        dp_in    = 4'b0010;
        lz_blank = 1'b0;
        step();
        load = 1'b0;
        en   = 1'b1;
        for (int k = 0; k < RD + 2; k++) begin
            step();
        end
        check("en_pre_an", 32'(an), 32'b0010);
        check("en_pre_dp", 32'(dp), 32'd1);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check_dark($sformatf("en_off%0d", k));
        end
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("en_res%0d_an", k), 32'(an), 32'b0010);
            check($sformatf("en_res%0d_seg", k), 32'(seg), 32'b1111001);
            check($sformatf("en_res%0d_dp", k), 32'(dp), 32'd1);
        end
        step();
        check("en_next_an", 32'(an), 32'b0100);
        check("en_next_dp", 32'(dp), 32'd0);

        // Reset mid-scan on digit 2, with a competing load
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        load     = 1'b1;
        bcd_in   = 16'h9A01;
        dp_in    = 4'b0000;
        lz_blank = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 2 * RD + 2; k++) begin
            step();
        end
        check("mid_an", 32'(an), 32'b0100);
        check("mid_orng", 32'(outrange), 32'd1);
        rst_n  = 1'b0;
        load   = 1'b1;
        bcd_in = 16'hFFFF;
        step();
        check_dark("mid_rst");
        check("mid_rst_orng", 32'(outrange), 32'd0);
        rst_n  = 1'b1;
        load   = 1'b0;
        step();
        check("mid_after_an", 32'(an), 32'b0001);
        check("mid_after_seg", 32'(seg), 32'b1111110);
        check("mid_after_orng", 32'(outrange), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
